serial_adder_disp: RTL and testbench
====================================

// Module: serial_adder_disp
// PURPOSE
//  Parametrised bit-serial add/subtract unit with an integrated multiplexed 7-segment hex display.
//  Generalises the 4-bit ripple adder/display path:
//   - operand width is a parameter
//   - add/sub mode
//   - start/busy/done handshake
//   - registered result
//   - scanned display of N digits with blanking of unused digits
//  Sits between the board switches/buttons and the seg/anode pins.
// PARAMETERS
//  WIDTH     8   operand width in bits (>=2); the result is WIDTH+1 bits
//  DIGITS    4   number of 7-seg digits scanned (>=1)
//  DIV_BITS  16  refresh prescaler width; the digit advances every 2**DIV_BITS mclk cycles
// PORTS
//  mclk   in   1         system clock; all state is on posedge mclk
//  rs     in   1         reset, asynchronous, active-high
//  a      in   WIDTH     operand A, sampled on the start edge only
//  b      in   WIDTH     operand B, sampled on the start edge only
//  sub    in   1         0 = A+B, 1 = A-B; sampled on the start edge
//  start  in   1         request; accepted only in IDLE
//  busy   out  1         high while in CALC
//  done   out  1         one-cycle pulse; sum is valid from this cycle on
//  sum    out  WIDTH+1   registered result; sum[WIDTH] = raw carry-out
//  seg    out  8         {dp,g,f,e,d,c,b,a}, active-low; dp always 1 (off)
//  anode  out  DIGITS    digit enables, active-low, one-cold
// BEHAVIOUR
//  Reset (async, while rs=1):
//   - state=IDLE, busy=0, done=0, sum=0
//   - digit select=0, prescaler=0
//   - anode={DIGITS-1{1'b1},1'b0}, seg=8'hC0 (glyph "0")
//  FSM: IDLE -> CALC -> DONE -> IDLE.
//   - IDLE: if start=1 at an edge, latch the operands:
//       opa=a; opb = sub ? ~b : b; carry = sub; idx=0; go to CALC.
//     Otherwise stay in IDLE.
//   - CALC: each edge computes one bit into an internal shift register:
//       r[idx] = opa[idx]^opb[idx]^carry; carry = majority(opa[idx],opb[idx],carry); idx++.
//     When the edge processes idx=WIDTH-1, load sum={carry,r} and go to DONE.
//   - DONE: done=1 for exactly one cycle, then go unconditionally to IDLE.
//  Latency:
//   - Start accepted at edge 0.
//   - busy=1 in the cycles after edges 0..WIDTH-1.
//   - sum updates and done=1 after edge WIDTH.
//   - The earliest next start is accepted at edge WIDTH+2.
//  start while in CALC or DONE is ignored, not queued. a, b and sub may change freely after the start edge.
//  sum holds its last value until the next completed operation; it never shows partial results.
//  Subtract: two's complement. sum[WIDTH]=1 means no borrow (A>=B unsigned). No separate overflow flag.
//  Display:
//   - The free-running prescaler wraps every 2**DIV_BITS cycles; on wrap, the digit select goes to (sel+1) mod DIGITS.
//   - anode = ~(1<<sel).
//   - Digit i shows hex nibble sum[4i+3:4i], zero-extended above bit WIDTH.
//   - Digits with 4i > WIDTH are blanked (seg=8'hFF).
//   - seg and anode are registered and change on the same edge.
//  Glyphs (hex, active-low, {dp,g..a}):
//   0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
//   8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
//  Reset mid-CALC aborts the operation: sum=0 and done is never pulsed. Display scanning runs in every state.
// TESTING (WIDTH=8, DIGITS=4, DIV_BITS=2 unless stated)
//  1. a=5A, b=3C, sub=0, start pulse -> busy for 8 cycles; done after edge 8; sum=9'h096.
//  2. a=FF, b=01, sub=0 -> sum=9'h100. Then a=10, b=01, sub=1 -> sum=9'h10F (no borrow).
//  3. a=01, b=02, sub=1 -> sum=9'h0FF (sum[8]=0, borrow).
//  4. Extra start pulses at edges 3 and 9 of an operation -> ignored; exactly one done, sum unchanged by them.
//  5. Assert rs at CALC edge 4 -> busy=0, sum=0, no done pulse; a new start after release gives the correct result.
//  6. sum=096:
//     - anode steps E,D,B,7 every 4 cycles
//     - seg steps 82,90,C0,FF (digit 3 blanked)
//     - wraps back to E.

Source files
------------

// File: rtl/serial_adder_disp_if.sv
// Operand/result handshake bundle between the board controls and the serial adder.
// start is sampled only in IDLE; done pulses for one cycle, and sum stays valid from then on.
interface serial_adder_disp_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   sum;
    logic [1:0]       dbg_state;

    modport master (output a, b, sub, start, input busy, done, sum, dbg_state);
    modport slave  (input a, b, sub, start, output busy, done, sum, dbg_state);
endinterface

// File: rtl/serial_adder_disp.sv
// Bit-serial add/subtract unit (one bit per clock) with a scanned, multiplexed
// 7-segment hex display of the registered result.
module serial_adder_disp #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 4,
    parameter int DIV_BITS = 16
) (
    input  logic               mclk,
    input  logic               rs,
    serial_adder_disp_if.slave bus,
    output logic [7:0]         seg,
    output logic [DIGITS-1:0]  anode
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int EW = (WIDTH + 1 > 4 * DIGITS) ? WIDTH + 1 : 4 * DIGITS;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      opa_q, opa_d, opb_q, opb_d, r_q, r_d;
    logic                  carry_q, carry_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [WIDTH:0]        sum_q, sum_d;
    logic [DIV_BITS-1:0]   presc_q, presc_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic [7:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     anode_q, anode_d;
    logic                  last_bit;
    logic [EW-1:0]         sum_ext;
    logic [3:0]            nib;

    assign last_bit = (idx_q == IW'(WIDTH - 1));

    always_ff @(posedge mclk or posedge rs) begin
        if (rs) state_q <= IDLE;
        else    state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q == CALC);
        bus.done      = (state_q == DONE);
        bus.sum       = sum_q;
        bus.dbg_state = state_q;
    end

    // Subtraction is A + ~B + 1: the inverted operand and initial carry are set at start.
    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        r_d     = r_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: if (bus.start) begin
                opa_d   = bus.a;
                opb_d   = bus.sub ? ~bus.b : bus.b;
                carry_d = bus.sub;
                idx_d   = '0;
            end
            CALC: begin
                r_d[idx_q] = opa_q[idx_q] ^ opb_q[idx_q] ^ carry_q;
                carry_d    = (opa_q[idx_q] & opb_q[idx_q]) | (opa_q[idx_q] & carry_q) |
                             (opb_q[idx_q] & carry_q);
                idx_d      = idx_q + IW'(1);
                if (last_bit) sum_d = {carry_d, r_d};
            end
            default: ;
        endcase
    end

    always_ff @(posedge mclk or posedge rs) begin
        if (rs) begin
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            r_q     <= '0;
            sum_q   <= '0;
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            r_q     <= r_d;
            sum_q   <= sum_d;
        end
    end

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;  4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;  4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
        endcase
    endfunction

    // seg/anode are built from the next select so both flip on the same edge as sel.
    always_comb begin
        presc_d = presc_q + DIV_BITS'(1);
        sel_d   = sel_q;
        if (&presc_q) sel_d = (sel_q == SW'(DIGITS - 1)) ? '0 : sel_q + SW'(1);
        sum_ext = EW'(sum_q);
        nib     = sum_ext[{sel_d, 2'b00} +: 4];
        anode_d = ~(DIGITS'(1) << sel_d);
        seg_d   = (4 * int'(sel_d) > WIDTH) ? 8'hFF : glyph(nib);
    end

    always_ff @(posedge mclk or posedge rs) begin
        if (rs) begin
            presc_q <= '0;
            sel_q   <= '0;
            anode_q <= ~DIGITS'(1);
            seg_q   <= 8'hC0;
        end else begin
            presc_q <= presc_d;
            sel_q   <= sel_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

    assign seg   = seg_q;
    assign anode = anode_q;
endmodule

// File: tb/tb_serial_adder_disp.sv
// Directed bench for serial_adder_disp (WIDTH=8, DIGITS=4, DIV_BITS=2) with an expected-result queue.
module tb_serial_adder_disp;
    localparam int W = 8;

    logic       mclk = 1'b0;
    logic       rs   = 1'b1;
    logic [7:0] seg;
    logic [3:0] anode;
    int         tests = 0;
    int         fails = 0;
    logic [W:0] exp_q[$];
    logic [W:0] exp_v;

    serial_adder_disp_if #(.WIDTH(W)) bus ();

    serial_adder_disp #(.WIDTH(W), .DIGITS(4), .DIV_BITS(2)) dut (
        .mclk(mclk), .rs(rs), .bus(bus), .seg(seg), .anode(anode)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
        if (ts) model = {1'b0, ta} + {1'b0, ~tb} + 9'd1;
        else    model = {1'b0, ta} + {1'b0, tb};
    endfunction

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts, input string tag);
        int busy_cnt = 0;
        bit got = 0;
        @(negedge mclk);
        bus.a = ta; bus.b = tb; bus.sub = ts; bus.start = 1'b1;
        exp_q.push_back(model(ta, tb, ts));
        @(posedge mclk); #1;
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.sub = 1'($urandom);
        for (int i = 0; i < W + 4 && !got; i++) begin
            if (bus.done) got = 1;
            else begin
                if (bus.busy) busy_cnt++;
                @(posedge mclk); #1;
            end
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_busy_cycles"}, busy_cnt, W);
        exp_v = exp_q.pop_front();
        check(tag, 32'(bus.sum), 32'(exp_v));
        @(posedge mclk); #1;
        check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int busy_cnt;
        bit found;
        logic [3:0] prev_an;
        logic [3:0] an_tab [5];
        logic [7:0] sg_tab [5];
        an_tab = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
        sg_tab = '{8'h82, 8'h90, 8'hC0, 8'hFF, 8'h82};
        bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.start = 1'b0;

        repeat (3) @(posedge mclk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_anode", 32'(anode), 32'hE);
        check("rst_seg", 32'(seg), 32'hC0);
        @(negedge mclk); rs = 1'b0;

        do_op(8'h5A, 8'h3C, 1'b0, "add_5a_3c");
        do_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
        do_op(8'h10, 8'h01, 1'b1, "sub_10_01");
        do_op(8'h01, 8'h02, 1'b1, "sub_01_02");
        for (int k = 0; k < 4; k++)
            do_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "rand_op");

        // Extra start pulses at edges 3 and 9 of one operation.
        @(negedge mclk);
        bus.a = 8'h77; bus.b = 8'h19; bus.sub = 1'b0; bus.start = 1'b1;
        exp_q.push_back(model(8'h77, 8'h19, 1'b0));
        @(posedge mclk); #1; bus.start = 1'b0;
        repeat (2) @(posedge mclk);
        @(negedge mclk); bus.a = 8'h00; bus.b = 8'h00; bus.start = 1'b1;
        @(posedge mclk); #1; bus.start = 1'b0;
        done_cnt = 0;
        for (int i = 4; i <= 8; i++) begin
            @(posedge mclk); #1;
            if (bus.done) done_cnt++;
        end
        @(negedge mclk); bus.start = 1'b1;
        @(posedge mclk); #1; bus.start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done) done_cnt++;
            if (bus.busy) busy_cnt++;
            @(posedge mclk); #1;
        end
        check("ignored_start_done_count", done_cnt, 1);
        check("ignored_start_no_busy", busy_cnt, 0);
        exp_v = exp_q.pop_front();
        check("ignored_start_sum", 32'(bus.sum), 32'(exp_v));

        // Reset at CALC edge 4 aborts the operation.
        @(negedge mclk);
        bus.a = 8'h33; bus.b = 8'h44; bus.sub = 1'b0; bus.start = 1'b1;
        @(posedge mclk); #1; bus.start = 1'b0;
        repeat (4) @(posedge mclk);
        #1; rs = 1'b1; #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        @(negedge mclk); rs = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge mclk); #1;
            if (bus.done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        do_op(8'h33, 8'h44, 1'b0, "after_abort");

        // Display scan with sum = 096.
        do_op(8'h5A, 8'h3C, 1'b0, "disp_setup");
        found = 0;
        prev_an = anode;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge mclk); #1;
            if (anode == 4'hE && prev_an != 4'hE) found = 1;
            prev_an = anode;
        end
        check("disp_found_digit0", 32'(found), 32'd1);
        for (int s = 0; s < 5; s++) begin
            check("disp_anode", 32'(anode), 32'(an_tab[s]));
            check("disp_seg", 32'(seg), 32'(sg_tab[s]));
            repeat (3) @(posedge mclk);
            #1;
            check("disp_hold", 32'(anode), 32'(an_tab[s]));
            @(posedge mclk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
